// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer for the 5-stage pipeline. Owns the program
//   counter, presents it to a combinational instruction memory and captures
//   the returned word into the IF/ID pipeline register. Honours redirect,
//   flush and stall requests, stops fetching at the end of the program and
//   latches a sticky fault on a misaligned redirect target.
//
// Parameters
//   RESET_PC    byte address fetched first after reset (word aligned)
//   IMEM_WORDS  number of 32-bit words in instruction memory
//   NOP_INST    instruction placed in IF/ID on bubbles
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   stall_i          hold PC, IF/ID and fetch count
//   flush_i          squash the IF/ID slot being written this cycle
//   redirect_i       taken branch/jump from EX
//   redirect_pc_i    redirect target byte address
//   imem_addr_o      byte address to imem (the PC register)
//   imem_inst_i      instruction returned combinationally by imem
//   if_id_pc_o       PC of the instruction held in IF/ID
//   if_id_inst_o     instruction held in IF/ID
//   if_id_valid_o    IF/ID holds a real instruction
//   halted_o         fetch stopped at end of program
//   fault_o          misaligned redirect seen; sticky until rst
//   fetch_count_o    instructions delivered into IF/ID (wraps)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] count_q, count_d;

  logic        pc_in_range;
  logic        redirect_aligned;

  // Word index compared against depth; upper bits included so any PC past the
  // end of memory (including wrapped-high addresses) is refused.
  assign pc_in_range      = ({2'b00, pc_q[31:2]} < IMEM_WORDS);
  assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    count_d       = count_q;

    unique case (state_q)
      FAULT: begin
        // Terminal until reset: keep emitting bubbles at the frozen PC.
        if_id_pc_d    = pc_q;
        if_id_inst_d  = NOP_INST;
        if_id_valid_d = 1'b0;
      end

      default: begin
        if (redirect_i) begin
          // Redirect outranks flush and stall in BOOT, RUN and HALT alike.
          if_id_pc_d    = pc_q;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
          if (redirect_aligned) begin
            pc_d    = redirect_pc_i;
            state_d = RUN;
          end else begin
            state_d = FAULT;
          end
        end else begin
          unique case (state_q)
            BOOT: begin
              // Single settling cycle: IF/ID keeps its reset bubble.
              state_d = RUN;
            end

            HALT: begin
              if_id_pc_d    = pc_q;
              if_id_inst_d  = NOP_INST;
              if_id_valid_d = 1'b0;
            end

            RUN: begin
              if (flush_i) begin
                // PC is not advanced, so the squashed instruction is refetched.
                if_id_pc_d    = pc_q;
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
              end else if (stall_i) begin
                // Everything holds.
              end else if (pc_in_range) begin
                if_id_pc_d    = pc_q;
                if_id_inst_d  = imem_inst_i;
                if_id_valid_d = 1'b1;
                pc_d          = pc_q + 32'd4;
                count_d       = count_q + 32'd1;
              end else begin
                if_id_pc_d    = pc_q;
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
                state_d       = HALT;
              end
            end

            default: begin
              state_d = state_q;
            end
          endcase
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      count_q       <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all taken straight from registers
  // ---------------------------------------------------------------------------
  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_inst_o  = if_id_inst_q;
  assign if_id_valid_o = if_id_valid_q;
  assign halted_o      = (state_q == HALT);
  assign fault_o       = (state_q == FAULT);
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl with a 6-word instruction memory.
//   Instruction memory is modelled as inst = 0xC0DE0000 ^ byte address.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_inst_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic        fault_o;
  logic [31:0] fetch_count_o;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_model(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign imem_inst_i = imem_model(imem_addr_o);

  fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(6),
    .NOP_INST  (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_inst_i  (imem_inst_i),
    .if_id_pc_o   (if_id_pc_o),
    .if_id_inst_o (if_id_inst_o),
    .if_id_valid_o(if_id_valid_o),
    .halted_o     (halted_o),
    .fault_o      (fault_o),
    .fetch_count_o(fetch_count_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        valid;
    logic        halted;
    logic        fault;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic [31:0] e_ipc;
    logic        e_valid;
    logic        e_halted;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input string nm, input logic r, input logic s,
                              input logic f, input logic rd, input logic [31:0] rp,
                              input logic [31:0] ea, input logic [31:0] ep,
                              input logic ev, input logic eh, input logic ef,
                              input logic [31:0] ec);
    vec_t v;
    v.name = nm; v.rst = r; v.stall = s; v.flush = f; v.redir = rd; v.rpc = rp;
    v.e_addr = ea; v.e_ipc = ep; v.e_valid = ev; v.e_halted = eh;
    v.e_fault = ef; v.e_cnt = ec;
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.addr = imem_addr_o; o.ipc = if_id_pc_o; o.inst = if_id_inst_o;
    o.valid = if_id_valid_o; o.halted = halted_o; o.fault = fault_o;
    o.cnt = fetch_count_o;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got addr=%h pc=%h inst=%h v=%b h=%b f=%b cnt=%0d | want addr=%h pc=%h inst=%h v=%b h=%b f=%b cnt=%0d",
               nm, got.addr, got.ipc, got.inst, got.valid, got.halted, got.fault, got.cnt,
               exp.addr, exp.ipc, exp.inst, exp.valid, exp.halted, exp.fault, exp.cnt);
    end
  endtask

  // Drive one vector, push its expectation, clock, then pop and compare.
  task automatic apply(input vec_t v);
    obs_t e;
    rst = v.rst; stall_i = v.stall; flush_i = v.flush;
    redirect_i = v.redir; redirect_pc_i = v.rpc;
    e.addr = v.e_addr; e.ipc = v.e_ipc; e.valid = v.e_valid;
    e.inst = v.e_valid ? imem_model(v.e_ipc) : NOP;
    e.halted = v.e_halted; e.fault = v.e_fault; e.cnt = v.e_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(v.name, sample(), sb.pop_front());
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    @(negedge clk);

    //                 name          rst st fl rd rpc       addr   ipc    v  h  f  cnt
    vecs.push_back(mk("reset0",      1, 0, 0, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk("reset1",      1, 0, 0, 1, 32'h10, 32'h00, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk("boot",        0, 0, 0, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk("fetch0",      0, 0, 0, 0, 32'h00, 32'h04, 32'h00, 1, 0, 0, 1));
    vecs.push_back(mk("fetch4",      0, 0, 0, 0, 32'h00, 32'h08, 32'h04, 1, 0, 0, 2));
    vecs.push_back(mk("stall1",      0, 1, 0, 0, 32'h00, 32'h08, 32'h04, 1, 0, 0, 2));
    vecs.push_back(mk("stall2",      0, 1, 0, 0, 32'h00, 32'h08, 32'h04, 1, 0, 0, 2));
    vecs.push_back(mk("stall3",      0, 1, 0, 0, 32'h00, 32'h08, 32'h04, 1, 0, 0, 2));
    vecs.push_back(mk("resume8",     0, 0, 0, 0, 32'h00, 32'h0C, 32'h08, 1, 0, 0, 3));
    vecs.push_back(mk("flush12",     0, 0, 1, 0, 32'h00, 32'h0C, 32'h0C, 0, 0, 0, 3));
    vecs.push_back(mk("refetch12",   0, 0, 0, 0, 32'h00, 32'h10, 32'h0C, 1, 0, 0, 4));
    vecs.push_back(mk("redir_stall", 0, 1, 0, 1, 32'h10, 32'h10, 32'h10, 0, 0, 0, 4));
    vecs.push_back(mk("target16",    0, 0, 0, 0, 32'h00, 32'h14, 32'h10, 1, 0, 0, 5));
    vecs.push_back(mk("fetch20",     0, 0, 0, 0, 32'h00, 32'h18, 32'h14, 1, 0, 0, 6));
    vecs.push_back(mk("halt_entry",  0, 0, 0, 0, 32'h00, 32'h18, 32'h18, 0, 1, 0, 6));
    vecs.push_back(mk("halt_hold",   0, 0, 0, 0, 32'h00, 32'h18, 32'h18, 0, 1, 0, 6));
    vecs.push_back(mk("halt_stfl",   0, 1, 1, 0, 32'h00, 32'h18, 32'h18, 0, 1, 0, 6));
    vecs.push_back(mk("halt_redir4", 0, 0, 0, 1, 32'h04, 32'h04, 32'h18, 0, 0, 0, 6));
    vecs.push_back(mk("after_halt4", 0, 0, 0, 0, 32'h00, 32'h08, 32'h04, 1, 0, 0, 7));
    vecs.push_back(mk("redir_mis6",  0, 0, 0, 1, 32'h06, 32'h08, 32'h08, 0, 0, 1, 7));
    vecs.push_back(mk("fault_redir", 0, 0, 0, 1, 32'h00, 32'h08, 32'h08, 0, 0, 1, 7));
    vecs.push_back(mk("fault_hold",  0, 0, 0, 0, 32'h00, 32'h08, 32'h08, 0, 0, 1, 7));
    vecs.push_back(mk("rst_redir",   1, 0, 0, 1, 32'h10, 32'h00, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk("boot2",       0, 0, 0, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk("fetch0b",     0, 0, 0, 0, 32'h00, 32'h04, 32'h00, 1, 0, 0, 1));
    vecs.push_back(mk("redir_flush", 0, 0, 1, 1, 32'h14, 32'h14, 32'h04, 0, 0, 0, 1));
    vecs.push_back(mk("target20",    0, 0, 0, 0, 32'h00, 32'h18, 32'h14, 1, 0, 0, 2));
    vecs.push_back(mk("rst_mid",     1, 0, 0, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk("boot_redir8", 0, 0, 0, 1, 32'h08, 32'h08, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk("target8",     0, 0, 0, 0, 32'h00, 32'h0C, 32'h08, 1, 0, 0, 1));

    foreach (vecs[i]) apply(vecs[i]);

    // Free-run from reset: halted_o must rise on exactly the 8th edge after
    // release (BOOT + six fetches + the refused one), with six fetches counted.
    begin
      int edges;
      obs_t e;
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      edges = 0;
      while (!halted_o && edges < 40) begin
        @(posedge clk); #1;
        edges++;
      end
      n_cmp++;
      if (edges != 8) begin
        n_bad++;
        $display("FAIL halt_latency: got %0d edges, want 8", edges);
      end
      e.addr = 32'h18; e.ipc = 32'h18; e.inst = NOP; e.valid = 1'b0;
      e.halted = 1'b1; e.fault = 1'b0; e.cnt = 32'd6;
      check("freerun_halt", sample(), e);
    end

    // Misaligned redirect straight out of BOOT faults without moving PC.
    begin
      obs_t e;
      rst = 1'b1; @(posedge clk); #1;
      rst = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0009;
      @(posedge clk); #1;
      redirect_i = 1'b0;
      e.addr = 32'h0; e.ipc = 32'h0; e.inst = NOP; e.valid = 1'b0;
      e.halted = 1'b0; e.fault = 1'b1; e.cnt = 32'd0;
      check("boot_misaligned", sample(), e);
      repeat (3) @(posedge clk);
      #1;
      check("fault_sticky", sample(), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so a stuck run still ends with a summary.
  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 5-stage pipeline. Owns the program counter, drives the combinational instruction memory's word-aligned byte address and captures the returned instruction into the IF/ID pipeline register. Applies stall, flush and branch-redirect requests from the hazard unit and EX stage. Detects end-of-program (PC beyond imem depth) and misaligned redirect targets.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset (word aligned)
- IMEM_WORDS, 64, number of 32-bit words in instruction memory; valid word indices 0..IMEM_WORDS-1
- NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID on bubbles
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hazard unit: hold PC and IF/ID
- flush_i  in  1  squash the IF/ID slot being written this cycle
- redirect_i  in  1  EX stage: taken branch/jump
- redirect_pc_i  in  32  target byte address, sampled when redirect_i=1
- imem_addr_o  out  32  byte address to imem (equals PC register)
- imem_inst_i  in  32  instruction returned combinationally by imem
- if_id_pc_o  out  32  PC of instruction in IF/ID
- if_id_inst_o  out  32  instruction in IF/ID
- if_id_valid_o  out  1  IF/ID holds a real instruction
- halted_o  out  1  fetch stopped at end of program
- fault_o  out  1  misaligned redirect seen; sticky until rst
- fetch_count_o  out  32  instructions delivered into IF/ID (wraps)

## Operation
- States: BOOT, RUN, HALT, FAULT. Reset enters BOOT.
- Reset values: PC=RESET_PC, if_id_pc_o=0, if_id_inst_o=NOP_INST, if_id_valid_o=0, halted_o=0, fault_o=0, fetch_count_o=0.
- imem_addr_o is the PC register directly; no combinational path from any input.
- Per-cycle priority: rst > redirect_i > flush_i > stall_i > normal fetch.
- BOOT: one cycle, IF/ID keeps bubble, PC holds; next state RUN. redirect_i in BOOT is processed as in RUN.
- RUN, normal fetch: if PC[31:2] < IMEM_WORDS: IF/ID <= {PC, imem_inst_i, valid=1}; PC <= PC+4; fetch_count_o += 1. Else: IF/ID <= bubble, PC holds, state -> HALT.
- redirect_i (RUN/BOOT/HALT): if redirect_pc_i[1:0]==0: PC <= redirect_pc_i, IF/ID <= bubble, state -> RUN. If misaligned: PC holds, IF/ID <= bubble, state -> FAULT. Redirect overrides concurrent stall_i and flush_i.
- flush_i (no redirect): IF/ID <= bubble, PC holds (instruction at PC refetched next cycle), count unchanged.
- stall_i (no redirect, no flush): PC, IF/ID, count all hold.
- HALT: IF/ID <= bubble each cycle, PC holds; only aligned redirect or rst leaves. stall_i/flush_i have no extra effect.
- FAULT: IF/ID <= bubble, PC holds; all inputs except rst ignored.
- Bubble = {if_id_pc_o=PC at that cycle, if_id_inst_o=NOP_INST, if_id_valid_o=0}.
- halted_o = (state==HALT), fault_o = (state==FAULT), both registered.
- PC+4 and fetch_count_o wrap modulo 2^32.

## Timing
- Fetch latency: instruction at PC appears on if_id_* one edge after PC is presented (imem read is same-cycle).
- First valid IF/ID after rst deasserts: edge 2 (BOOT edge 1, RUN fetch edge 2), carrying RESET_PC.
- Redirect penalty: asserting redirect_i at edge n gives bubble at n, target instruction valid at n+1.
- Stall for k cycles holds outputs exactly k cycles; fetch resumes the cycle stall_i drops.
- HALT entry: halted_o rises on the same edge the first out-of-range fetch is refused; falls on the edge an aligned redirect is taken.
- rst mid-operation overrides everything on that edge, including a simultaneous redirect.

## Test plan
- Reset then free-run, IMEM_WORDS=6: if_id_pc_o sequence 0,4,...,20 valid; at PC=24 halted_o=1, valid=0, fetch_count_o=6.
- stall_i high 3 cycles at PC=8: if_id_pc_o stays 4 for 3 cycles, imem_addr_o stays 8, count unchanged; resumes with 8.
- redirect_i with redirect_pc_i=0x10 and stall_i both high: bubble next edge, then if_id_pc_o=0x10 valid; redirect wins.
- flush_i alone at PC=12: IF/ID valid=0, NOP_INST; next edge if_id_pc_o=12 valid (refetch).
- In HALT, redirect to 0x4: halted_o clears, instruction at 0x4 valid one edge later; redirect to 0x6: fault_o=1, stays until rst.
- rst asserted mid-run with redirect_i=1: all outputs return to reset values, BOOT then RESET_PC fetched.
